// File: rtl/servo180_pwm_gen.sv
// servo180_pwm_gen
//   Hobby-servo PWM generator fed by the servo180 register file. Turns a
//   0..180 degree command into a PWM_FREQ_HZ frame carrying a
//   MIN_PULSE_US..MAX_PULSE_US pulse. All output-affecting state (enable,
//   angle, pulse width) loads only on the last cycle of a frame, so a pulse
//   is never cut short or stretched. Optional slew limiting moves the driven
//   angle by at most STEP_DEG per frame.
//
// Ports
//   ACLK           clock
//   ARESETN        synchronous active-low reset
//   angle_i        commanded angle (degrees)
//   angle_we_i     one-cycle strobe, samples angle_i into the target
//   enable_i       output enable level, sampled at frame boundaries
//   slew_en_i      1: rate-limit toward target, 0: jump to target
//   err_clr_i      one-cycle strobe, clears err_o
//   pwm_o          registered servo PWM
//   period_tick_o  one-cycle pulse while the frame counter is 0
//   cur_angle_o    angle currently being driven
//   busy_o         cur_angle_o differs from the target
//   err_o          sticky flag: a command above 180 was written
module servo180_pwm_gen #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int PWM_FREQ_HZ  = 50,
  parameter int MIN_PULSE_US = 500,
  parameter int MAX_PULSE_US = 2500,
  parameter int STEP_DEG     = 1
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [7:0] angle_i,
  input  logic       angle_we_i,
  input  logic       enable_i,
  input  logic       slew_en_i,
  input  logic       err_clr_i,
  output logic       pwm_o,
  output logic       period_tick_o,
  output logic [7:0] cur_angle_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int TPU       = CLK_FREQ_HZ / 1_000_000;
  localparam int PERIOD    = CLK_FREQ_HZ / PWM_FREQ_HZ;
  localparam int DEG_TICKS = ((MAX_PULSE_US - MIN_PULSE_US) * TPU) / 180;
  localparam int CW        = $clog2(PERIOD);

  localparam logic [31:0]   MIN_TICKS = 32'(MIN_PULSE_US * TPU);
  localparam logic [31:0]   DEG_K     = 32'(DEG_TICKS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [7:0]    ANG_MAX   = 8'd180;
  localparam logic [7:0]    ANG_RST   = 8'd90;
  localparam logic [7:0]    STEP8     = 8'(STEP_DEG);
  localparam logic [CW-1:0] PT_RST    = CW'(MIN_TICKS + 32'(ANG_RST) * DEG_K);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    cur_angle_q, cur_angle_d;
  logic [CW-1:0] pulse_ticks_q, pulse_ticks_d;
  logic          enable_q, enable_d;
  logic          pwm_q, pwm_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;

  logic          boundary;
  logic [7:0]    diff, step, next_angle;

  always_comb begin
    boundary = (cnt_q == CNT_LAST);

    // Free-running frame counter.
    cnt_d = boundary ? '0 : cnt_q + 1'b1;

    // Slew step: never larger than the remaining distance, so no overshoot.
    diff = (target_q >= cur_angle_q) ? (target_q - cur_angle_q)
                                     : (cur_angle_q - target_q);
    step = (diff < STEP8) ? diff : STEP8;
    if (!slew_en_i)                    next_angle = target_q;
    else if (target_q >= cur_angle_q)  next_angle = cur_angle_q + step;
    else                               next_angle = cur_angle_q - step;

    // Writes land in target only; a write on the boundary cycle is seen
    // next frame because the boundary below reads the old target_q.
    target_d = target_q;
    if (angle_we_i) target_d = (angle_i > ANG_MAX) ? ANG_MAX : angle_i;

    // Set wins over clear.
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (angle_we_i && (angle_i > ANG_MAX)) err_d = 1'b1;

    enable_d      = enable_q;
    cur_angle_d   = cur_angle_q;
    pulse_ticks_d = pulse_ticks_q;
    if (boundary) begin
      enable_d      = enable_i;
      cur_angle_d   = next_angle;
      pulse_ticks_d = CW'(MIN_TICKS + 32'(next_angle) * DEG_K);
    end

    // pwm for counter value c appears the cycle after c. At c = PERIOD-1
    // the compare is always false, so the boundary reload cannot glitch it.
    pwm_d  = enable_q && (cnt_q < pulse_ticks_q);
    tick_d = (cnt_d == '0);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt_q         <= '0;
      target_q      <= ANG_RST;
      cur_angle_q   <= ANG_RST;
      pulse_ticks_q <= PT_RST;
      enable_q      <= 1'b0;
      pwm_q         <= 1'b0;
      tick_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      cur_angle_q   <= cur_angle_d;
      pulse_ticks_q <= pulse_ticks_d;
      enable_q      <= enable_d;
      pwm_q         <= pwm_d;
      tick_q        <= tick_d;
      err_q         <= err_d;
    end
  end

  assign pwm_o         = pwm_q;
  assign period_tick_o = tick_q;
  assign cur_angle_o   = cur_angle_q;
  assign busy_o        = (cur_angle_q != target_q);
  assign err_o         = err_q;

endmodule

// File: tb/tb_servo180_pwm_gen.sv
// Directed bench for servo180_pwm_gen. 1 MHz clock, 320 Hz frame
// (PERIOD = 3125 cycles) keeps the run short while the pulse widths stay
// those of a 1 us tick: DEG_TICKS = 11, 0 deg = 500, 90 deg = 1490,
// 180 deg = 2480 cycles.
module tb_servo180_pwm_gen;
  localparam int P = 3125;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [7:0] angle_i;
  logic       angle_we_i, enable_i, slew_en_i, err_clr_i;
  logic       pwm_o, period_tick_o, busy_o, err_o;
  logic [7:0] cur_angle_o;

  int total = 0;
  int bad   = 0;
  int w, hi, cyc;

  servo180_pwm_gen #(
    .CLK_FREQ_HZ (1_000_000),
    .PWM_FREQ_HZ (320),
    .MIN_PULSE_US(500),
    .MAX_PULSE_US(2500),
    .STEP_DEG    (1)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .angle_i      (angle_i),
    .angle_we_i   (angle_we_i),
    .enable_i     (enable_i),
    .slew_en_i    (slew_en_i),
    .err_clr_i    (err_clr_i),
    .pwm_o        (pwm_o),
    .period_tick_o(period_tick_o),
    .cur_angle_o  (cur_angle_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Strobe inputs for exactly one cycle, starting at the current negedge.
  task automatic drive(input logic we, input logic [7:0] a, input logic clr);
    angle_we_i = we; angle_i = a; err_clr_i = clr;
    @(negedge ACLK);
    angle_we_i = 1'b0; err_clr_i = 1'b0;
  endtask

  // Advance until period_tick_o (bounded); counts cycles and pwm highs seen.
  task automatic wait_tick(output int cycles, output int highs);
    cycles = 0; highs = 0;
    for (int k = 0; k < 2 * P; k++) begin
      @(negedge ACLK);
      cycles++;
      if (period_tick_o) break;
      highs += int'(pwm_o);
    end
  endtask

  // Called at a tick negedge (cnt == 0). Counts pwm highs over one frame,
  // optionally drops enable at cycle drop_at or writes at cycle wr_at, and
  // ends on the next tick negedge, checking frame spacing.
  task automatic measure(input string tag, input int drop_at, input int wr_at,
                         input logic [7:0] wr_val, output int width);
    int ticks;
    width = 0; ticks = 0;
    for (int i = 0; i < P; i++) begin
      if (i > 0) @(negedge ACLK);
      width += int'(pwm_o);
      ticks += int'(period_tick_o);
      if (i == drop_at) enable_i = 1'b0;
      angle_we_i = (i == wr_at);
      if (i == wr_at) angle_i = wr_val;
    end
    @(negedge ACLK);
    angle_we_i = 1'b0;
    chk({tag, "_ticks"}, ticks, 1);
    chk({tag, "_next_tick"}, int'(period_tick_o), 1);
  endtask

  initial begin
    ARESETN = 1'b0; angle_i = 8'd0; angle_we_i = 1'b0;
    enable_i = 1'b1; slew_en_i = 1'b0; err_clr_i = 1'b0;

    // 1. reset defaults
    repeat (3) @(negedge ACLK);
    chk("rst_pwm", int'(pwm_o), 0);
    chk("rst_tick", int'(period_tick_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_cur", int'(cur_angle_o), 90);
    ARESETN = 1'b1;
    wait_tick(cyc, hi);
    chk("first_frame_len", cyc, P);
    chk("first_frame_pwm", hi, 0);
    measure("f90", -1, -1, 8'd0, w);
    chk("w90", w, 1490);

    // 2. jump mode
    drive(1'b1, 8'd0, 1'b0);
    chk("jump0_busy", int'(busy_o), 1);
    wait_tick(cyc, hi);
    chk("jump0_wait", cyc, P - 1);
    chk("jump0_cur", int'(cur_angle_o), 0);
    chk("jump0_busy_done", int'(busy_o), 0);
    measure("f0", -1, -1, 8'd0, w);
    chk("w0", w, 500);
    drive(1'b1, 8'd180, 1'b0);
    chk("jump180_busy", int'(busy_o), 1);
    wait_tick(cyc, hi);
    chk("jump180_cur", int'(cur_angle_o), 180);
    chk("jump180_busy_done", int'(busy_o), 0);
    measure("f180", -1, -1, 8'd0, w);
    chk("w180", w, 2480);

    // 3. slew mode from 90 to 95
    drive(1'b1, 8'd90, 1'b0);
    wait_tick(cyc, hi);
    chk("slew_start", int'(cur_angle_o), 90);
    slew_en_i = 1'b1;
    drive(1'b1, 8'd95, 1'b0);
    wait_tick(cyc, hi);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("slew_cur%0d", i), int'(cur_angle_o), 91 + i);
      chk($sformatf("slew_busy%0d", i), int'(busy_o), (i < 4) ? 1 : 0);
      measure("fslew", -1, -1, 8'd0, w);
      chk($sformatf("slew_w%0d", i), w, 1501 + 11 * i);
    end
    chk("slew_hold", int'(cur_angle_o), 95);

    // 4. out-of-range
    drive(1'b1, 8'd200, 1'b0);
    chk("oor_err", int'(err_o), 1);
    chk("oor_busy", int'(busy_o), 1);
    repeat (10) @(negedge ACLK);
    chk("oor_sticky", int'(err_o), 1);
    drive(1'b0, 8'd0, 1'b1);
    chk("oor_clr", int'(err_o), 0);
    drive(1'b1, 8'd255, 1'b1);
    chk("oor_set_wins", int'(err_o), 1);
    slew_en_i = 1'b0;
    wait_tick(cyc, hi);
    chk("oor_clamp", int'(cur_angle_o), 180);
    chk("oor_busy_done", int'(busy_o), 0);

    // 5. enable drop mid-pulse, then write on the boundary cycle
    measure("fdrop", 1000, -1, 8'd0, w);
    chk("drop_full", w, 2480);
    enable_i = 1'b1;
    measure("foff", -1, P - 1, 8'd0, w);
    chk("off_frame", w, 0);
    chk("coll_cur_old", int'(cur_angle_o), 180);
    chk("coll_busy", int'(busy_o), 1);
    measure("fcoll", -1, -1, 8'd0, w);
    chk("coll_old_w", w, 2480);
    chk("coll_cur_new", int'(cur_angle_o), 0);
    chk("coll_busy_done", int'(busy_o), 0);

    // 6. reset during a high pulse
    repeat (100) @(negedge ACLK);
    chk("mid_pwm_hi", int'(pwm_o), 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_pwm", int'(pwm_o), 0);
    chk("mid_rst_cur", int'(cur_angle_o), 90);
    chk("mid_rst_err", int'(err_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    wait_tick(cyc, hi);
    chk("mid_restart_len", cyc, P);
    chk("mid_restart_pwm", hi, 0);
    measure("fpost", -1, -1, 8'd0, w);
    chk("post_w90", w, 1490);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
